// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the main pipeline (A, priority)
// and a FIFO-buffered long-latency unit (B), with bounded starvation of B.
module regfile_wb_arbiter #(
    parameter int B_DEPTH    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_waddr,
    input  logic [31:0] a_wdata,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_waddr,
    input  logic [31:0] b_wdata,
    output logic        b_ready,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    input  logic [4:0]  chk_addr,
    output logic        chk_hit
);

    localparam int PW = $clog2(B_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]         fifo_addr [B_DEPTH];
    logic [31:0]        fifo_data [B_DEPTH];
    logic [B_DEPTH-1:0] fifo_vld;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [SW-1:0]      starve_cnt;

    logic fifo_nonempty;
    logic fifo_full;
    logic force_b;
    logic a_is_r0;
    logic grant_a;
    logic grant_b;
    logic push;

    always_comb begin
        fifo_nonempty = |fifo_vld;
        fifo_full     = &fifo_vld;
        force_b       = fifo_nonempty && (starve_cnt == SW'(STARVE_MAX));
        a_is_r0       = (a_waddr == 5'd0);
        grant_b       = fifo_nonempty && (force_b || !a_valid || a_is_r0);
        grant_a       = a_valid && !a_is_r0 && !grant_b;
        a_ready       = !force_b || a_is_r0;
        b_ready       = !fifo_full;
        // r0 pushes are handshaken but never stored: they could not write anything
        push          = b_valid && b_ready && (b_waddr != 5'd0);
    end

    always_comb begin
        chk_hit = 1'b0;
        if (chk_addr != 5'd0) begin
            if (we && (waddr == chk_addr)) begin
                chk_hit = 1'b1;
            end
            for (int i = 0; i < B_DEPTH; i++) begin
                if (fifo_vld[i] && (fifo_addr[i] == chk_addr)) begin
                    chk_hit = 1'b1;
                end
            end
        end
    end

    // FIFO storage: payload is qualified by fifo_vld, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_waddr;
            fifo_data[wr_ptr] <= b_wdata;
        end
    end

    // Control state and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_vld   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            starve_cnt <= '0;
            we         <= 1'b0;
            waddr      <= 5'd0;
            wdata      <= 32'd0;
        end else begin
            if (grant_b) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (push) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PW'(1);
            end

            if (grant_b || !fifo_nonempty) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (grant_a) begin
                we    <= 1'b1;
                waddr <= a_waddr;
                wdata <= a_wdata;
            end else if (grant_b) begin
                we    <= 1'b1;
                waddr <= fifo_addr[rd_ptr];
                wdata <= fifo_data[rd_ptr];
            end else begin
                we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queue-based reference model predicts
// handshakes and writes; a negedge monitor retires observed register-file writes.
module tb_regfile_wb_arbiter;

    localparam int B_DEPTH    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_waddr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_waddr = '0;
    logic [31:0] b_wdata = '0;
    logic        b_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  chk_addr = '0;
    logic        chk_hit;

    regfile_wb_arbiter #(.B_DEPTH(B_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_ready(a_ready),
        .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .chk_addr(chk_addr), .chk_hit(chk_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    wr_t        bq[$];
    int         starve = 0;
    logic       we_m = 1'b0;
    logic [4:0] waddr_m = '0;
    int         checks = 0;
    int         errors = 0;
    wr_t        mh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        bq.delete();
        starve  = 0;
        we_m    = 1'b0;
        waddr_m = '0;
    endtask

    // Apply one cycle of inputs, check combinational outputs, advance the model.
    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic [4:0] ca);
        bit  nonempty, force_b, gb, ga, exp_ar, exp_br, exp_hit;
        wr_t h;
        a_valid = av; a_waddr = aa; a_wdata = ad;
        b_valid = bv; b_waddr = ba; b_wdata = bd;
        chk_addr = ca;
        #1;
        nonempty = (bq.size() != 0);
        force_b  = nonempty && (starve == STARVE_MAX);
        exp_ar   = !force_b || (aa == 5'd0);
        exp_br   = (bq.size() < B_DEPTH);
        exp_hit  = 1'b0;
        if (ca != 5'd0) begin
            if (we_m && waddr_m == ca) exp_hit = 1'b1;
            foreach (bq[i]) if (bq[i].addr == ca) exp_hit = 1'b1;
        end
        chk("a_ready", 32'(a_ready), 32'(exp_ar));
        chk("b_ready", 32'(b_ready), 32'(exp_br));
        chk("chk_hit", 32'(chk_hit), 32'(exp_hit));
        gb = nonempty && (force_b || !av || aa == 5'd0);
        ga = av && (aa != 5'd0) && !gb;
        if (ga) begin
            sb.push_back('{addr: aa, data: ad});
            we_m = 1'b1; waddr_m = aa;
        end else if (gb) begin
            h = bq.pop_front();
            sb.push_back(h);
            we_m = 1'b1; waddr_m = h.addr;
        end else begin
            we_m = 1'b0;
        end
        if (gb || !nonempty) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        if (bv && exp_br && ba != 5'd0) bq.push_back('{addr: ba, data: bd});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] ca);
        repeat (n) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ca);
            tick();
        end
    endtask

    // Retire every observed write against the head of the expected-write queue.
    always @(negedge clk) begin
        if (rst && we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got write waddr=%0d wdata=0x%0h, required no write", waddr, wdata);
            end else begin
                mh = sb.pop_front();
                chk("wb_waddr", 32'(waddr), 32'(mh.addr));
                chk("wb_wdata", wdata, mh.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        av, bv;
        logic [4:0]  aa, ba, ca;

        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // A only
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0);
        chk("t1_a_ready", 32'(a_ready), 32'd1);
        tick();
        chk("t1_we", 32'(we), 32'd1);
        chk("t1_waddr", 32'(waddr), 32'd5);
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        idle(1, 5'd0);
        chk("t1_we_low", 32'(we), 32'd0);

        // B with A idle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 5'd7);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
        chk("t2_hit_t1", 32'(chk_hit), 32'd1);
        tick();
        chk("t2_we", 32'(we), 32'd1);
        chk("t2_waddr", 32'(waddr), 32'd7);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
        chk("t2_hit_t2", 32'(chk_hit), 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
        chk("t2_hit_t3", 32'(chk_hit), 32'd0);
        tick();

        // Starvation: A busy every cycle, B pushes r9 at t0
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(10 + i), $urandom, (i == 0), 5'd9, 32'h99, 5'd0);
            chk("t3_a_ready", 32'(a_ready), (i == 5) ? 32'd0 : 32'd1);
            if (i == 6) chk("t3_forced_waddr", 32'(waddr), 32'd9);
            if (i == 7) chk("t3_resume_waddr", 32'(waddr), 32'd16);
            tick();
        end
        idle(3, 5'd0);

        // Full FIFO while A is busy
        for (int i = 0; i < 6; i++) begin
            drive((i < 3), 5'(20 + i), $urandom, (i < 2), 5'(i + 1), 32'(100 + i), 5'd0);
            if (i == 2) chk("t4_b_ready_full", 32'(b_ready), 32'd0);
            if (i == 4) begin
                chk("t4_first_waddr", 32'(waddr), 32'd1);
                chk("t4_b_ready_free", 32'(b_ready), 32'd1);
            end
            if (i == 5) chk("t4_second_waddr", 32'(waddr), 32'd2);
            tick();
        end
        idle(2, 5'd0);

        // Both sources target r0
        drive(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB, 5'd0);
        chk("t5_a_ready", 32'(a_ready), 32'd1);
        chk("t5_chk_hit", 32'(chk_hit), 32'd0);
        tick();
        chk("t5_we", 32'(we), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
        chk("t5_fifo_empty", 32'(b_ready), 32'd1);
        tick();

        // Reset mid-operation with two FIFO entries pending and a write in flight
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hB11, 5'd0);
        tick();
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hB12, 5'd0);
        tick();
        chk("t6_pre_we", 32'(we), 32'd1);
        chk("t6_pre_full", 32'(b_ready), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0; chk_addr = 5'd11;
        rst = 1'b0;
        #1;
        chk("t6_we", 32'(we), 32'd0);
        chk("t6_waddr", 32'(waddr), 32'd0);
        chk("t6_wdata", wdata, 32'd0);
        chk("t6_b_ready", 32'(b_ready), 32'd1);
        chk("t6_chk_hit", 32'(chk_hit), 32'd0);
        model_reset();
        tick();
        rst = 1'b1;
        idle(4, 5'd11);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            av = ($urandom_range(0, 3) != 0);
            aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
            bv = $urandom_range(0, 1) != 0;
            ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
            ca = 5'($urandom_range(0, 15));
            drive(av, aa, $urandom, bv, ba, $urandom, ca);
            tick();
        end
        idle(12, 5'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
